sync_mutex_rr: RTL and testbench
================================

// Module: sync_mutex_rr
// PURPOSE
//  N-way synchronous mutex. Grants exclusive ownership of one shared resource
//  to one of N level-sensitive requesters.
//  Requests may arrive from unrelated clock domains; they are synchronised internally.
//  Arbitration is round-robin, so no requester starves. An optional hold timeout
//  revokes ownership from a requester that keeps the lock too long.
//  Sits between the per-core lock request lines and a shared peripheral or buffer.
// PARAMETERS
//  N            2   number of requesters, N >= 2
//  SYNC_STAGES  2   synchroniser flops per req bit; 0 = req already in clk domain
//  TIMEOUT      0   max grant length in cycles; 0 = no timeout; else >= 2
//  IDW          $clog2(N)   width of owner (localparam, not overridable)
// PORTS
//  clk      in   1    clock, all state on rising edge
//  rst_n    in   1    asynchronous active-low reset
//  req      in   N    level request per channel; hold high for as long as owned
//  gnt      out  N    one-hot (or zero) grant, registered
//  owner    out  IDW  index of current owner; valid only when busy=1
//  busy     out  1    1 while any gnt bit is high
//  timeout  out  1    one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset (rst_n=0, async): gnt=0, owner=0, busy=0, timeout=0, ptr=0,
//   synchroniser flops=0, stale=0, hold counter=0, state=IDLE.
//  req_s = req after SYNC_STAGES flops. Arbitration uses only req_s.
//  elig[i] = req_s[i] & ~stale[i].
//  FSM states:
//   IDLE:  if elig!=0, choose the first set bit scanning ptr, ptr+1, .. mod N.
//          Set gnt<=onehot(idx), owner<=idx, cnt<=0, busy<=1; go to GRANT.
//          Otherwise stay in IDLE.
//   GRANT: if req_s[owner]=0, this is a release:
//           gnt<=0, busy<=0, ptr<=(owner+1) mod N; go to GUARD.
//          Else if TIMEOUT>0, cnt==TIMEOUT-1, and some other elig bit is set,
//          this is a revoke:
//           gnt<=0, busy<=0, timeout<=1, stale[owner]<=1, ptr<=(owner+1) mod N;
//           go to GUARD.
//          Else cnt<=cnt+1, saturating at TIMEOUT-1.
//          With no competitor there is no revoke; ownership is held indefinitely.
//   GUARD: all gnt=0 for exactly one cycle; go to IDLE. This guarantees a
//          gap of at least 2 cycles with no grant between owners.
//  Latency: req rising with the resource free gives gnt high SYNC_STAGES+1
//   cycles later.
//  Handover: gnt[a] falls at edge k. gnt[b] rises at edge k+2 at the earliest.
//  Mutual exclusion: $onehot0(gnt) holds in every cycle. gnt[i] never rises
//   while req_s[i]=0.
//  stale[i] is cleared in any cycle where req_s[i]=0. A revoked requester must
//   drop req before it can win again.
//  Simultaneous requests in IDLE: round-robin order from ptr decides. ptr only
//   changes on release or revoke.
//  Owner drops req and another raises req in the same cycle: the release is
//   processed first; the new request is seen in IDLE.
//  Requester raises req while another owns: it waits, no effect on the current owner.
//  timeout pulse is high exactly one cycle; it is 0 in every other state.
//  Reset asserted mid-GRANT: gnt drops asynchronously and immediately, with no
//   glitch to another channel.
//  Glitch on req shorter than one clk may be missed; this is allowed. A
//   registered grant never glitches.
// TESTING
//  1. N=4, SYNC=2: req=0b0001 from idle -> gnt=0b0001 at cycle 3, owner=0, busy=1.
//  2. req=0b1111 held; each owner drops req after 5 cycles of grant, then
//     re-raises -> grant order 0,1,2,3,0; 2 idle cycles between grants.
//  3. ptr=2 after release by ch1, req=0b1011 -> gnt=0b1000 (ch3 wins, ch2 absent).
//  4. TIMEOUT=8, ch0 holds req, ch1 requests -> ch0 gnt falls after 8 grant cycles;
//     timeout=1 for 1 cycle; ch1 granted 2 cycles later; ch0 not re-granted until
//     its req drops then rises again.
//  5. TIMEOUT=8, only ch0 requests -> grant held 100 cycles, timeout never pulses.
//  6. rst_n low for 1 cycle mid-grant with random req -> all outputs 0 at once;
//     round-robin restarts from ch0. Assert $onehot0(gnt) throughout a 10k-cycle
//     random run.

Source files
------------

// File: rtl/sync_mutex_rr.sv
// -----------------------------------------------------------------------------
// sync_mutex_rr
//   N-way mutex guarding one shared resource. Level-sensitive requests, which
//   may come from unrelated clock domains, are synchronised into clk. Owners
//   are chosen round-robin. A grant can be revoked when it has been held for
//   TIMEOUT cycles and another requester is waiting. Owners are always
//   separated by at least two grant-free cycles.
//
// Parameters
//   N            number of requesters (>= 2)
//   SYNC_STAGES  synchroniser depth per request bit; 0 = req already in clk
//   TIMEOUT      maximum grant length in cycles; 0 = unlimited, else >= 2
//   IDW          owner index width (derived, not overridable)
//
// Ports
//   clk      clock, all state on the rising edge
//   rst_n    asynchronous active-low reset
//   req      [N]   level request per channel, held high while owned
//   gnt      [N]   registered one-hot (or zero) grant
//   owner    [IDW] index of current owner, valid only while busy
//   busy     1 while any grant bit is high
//   timeout  one-cycle pulse when a grant is revoked by timeout
// -----------------------------------------------------------------------------
module sync_mutex_rr #(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0,
    localparam int IDW        = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic           timeout
);

    // Hold counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [IDW:0]   N_W     = (IDW + 1)'(N);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GUARD
    } state_t;

    state_t         state, state_d;
    logic [N-1:0]   req_s;
    logic [N-1:0]   elig;
    logic [N-1:0]   stale, stale_d;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] owner_d;
    logic [IDW-1:0] ptr, ptr_d;
    logic [IDW-1:0] ptr_next_owner;
    logic [CW-1:0]  cnt, cnt_d;
    logic           busy_d;
    logic           timeout_d;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;

    // ------------------------------------------------------------------
    // Request synchroniser
    // ------------------------------------------------------------------
    if (SYNC_STAGES == 0) begin : g_nosync
        assign req_s = req;
    end else begin : g_sync
        logic [N-1:0] sync_q [SYNC_STAGES];

        // NOTE: this flop array is a synchroniser chain, not a memory, so it
        // is reset like any other state; a stale 1 here after reset would be
        // seen as a live request.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            end else begin
                sync_q[0] <= req;
                for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            end
        end

        assign req_s = sync_q[SYNC_STAGES-1];
    end

    // A revoked requester stays ineligible until it drops its request.
    assign elig = req_s & ~stale;

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible channel scanning ptr, ptr+1, ...
    // ------------------------------------------------------------------
    always_comb begin
        logic [IDW:0] j;
        // NOTE: every variable driven here gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, ptr} + (IDW + 1)'(k);
            if (j >= N_W) j = j - N_W;
            if (!pick_found && elig[j[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = j[IDW-1:0];
            end
        end
    end

    assign ptr_next_owner = (owner == LAST_ID) ? '0 : owner + IDW'(1);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state;
        gnt_d     = gnt;
        owner_d   = owner;
        busy_d    = busy;
        timeout_d = 1'b0;
        ptr_d     = ptr;
        cnt_d     = cnt;
        // Stale marks clear whenever the synchronised request is low.
        stale_d   = stale & req_s;

        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    cnt_d           = '0;
                    busy_d          = 1'b1;
                    state_d         = GRANT;
                end
            end

            GRANT: begin
                if (!req_s[owner]) begin
                    // Release takes priority over a coincident revoke.
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_next_owner;
                    state_d = GUARD;
                end else if (TIMEOUT > 0 && cnt == CNT_MAX && (elig & ~gnt) != '0) begin
                    // Revoke only when someone else is actually waiting.
                    gnt_d          = '0;
                    busy_d         = 1'b0;
                    timeout_d      = 1'b1;
                    stale_d[owner] = 1'b1;
                    ptr_d          = ptr_next_owner;
                    state_d        = GUARD;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CW'(1);
                end
            end

            GUARD: begin
                // One forced grant-free cycle before arbitrating again.
                state_d = IDLE;
            end

            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
            stale   <= '0;
        end else begin
            state   <= state_d;
            gnt     <= gnt_d;
            owner   <= owner_d;
            busy    <= busy_d;
            timeout <= timeout_d;
            ptr     <= ptr_d;
            cnt     <= cnt_d;
            stale   <= stale_d;
        end
    end

endmodule

// File: tb/tb_sync_mutex_rr.sv
// -----------------------------------------------------------------------------
// tb_sync_mutex_rr
//   Directed bench for sync_mutex_rr with N=4, SYNC_STAGES=2, TIMEOUT=8.
//   Inputs change 1 ns after a rising edge; outputs are sampled at the same
//   point, so "tick" count equals the number of rising edges elapsed.
// -----------------------------------------------------------------------------
module tb_sync_mutex_rr;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         busy;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_mutex_rr #(
        .N           (N),
        .SYNC_STAGES (2),
        .TIMEOUT     (TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_grant(input int max_cycles);
        int n;
        n = 0;
        while (gnt == '0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_grant", {31'b0, |gnt}, 32'd1);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (gnt != '0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_idle", {31'b0, |gnt}, 32'd0);
    endtask

    initial begin
        logic [N-1:0] oh;
        logic [N-1:0] oh_next;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        req   = '0;
        ticks(3);
        check("rst_gnt",     gnt,     0);
        check("rst_owner",   owner,   0);
        check("rst_busy",    busy,    0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;

        // ---------------- 1: single request latency ----------------
        req = 4'b0001;
        ticks(2);
        check("t1_gnt_c2", gnt, 4'b0000);
        tick();
        check("t1_gnt_c3",   gnt,   4'b0001);
        check("t1_owner_c3", owner, 0);
        check("t1_busy_c3",  busy,  1);
        req = 4'b0000;
        ticks(2);
        check("t1_gnt_held", gnt, 4'b0001);
        tick();
        check("t1_gnt_rel",  gnt,  4'b0000);
        check("t1_busy_rel", busy, 0);

        // Restart round-robin from ch0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // ---------------- 2: round-robin rotation ----------------
        req = 4'b1111;
        ticks(3);
        check("t2_first_gnt", gnt, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            oh      = 4'b0001 << k;
            oh_next = 4'b0001 << ((k + 1) % 4);
            ticks(5);
            req[k] = 1'b0;
            ticks(2);
            check("t2_hold", gnt, oh);
            tick();
            check("t2_gap1_gnt",  gnt,  4'b0000);
            check("t2_gap1_busy", busy, 0);
            req[k] = 1'b1;
            tick();
            check("t2_gap2_gnt", gnt, 4'b0000);
            tick();
            check("t2_next_gnt",   gnt,   oh_next);
            check("t2_next_owner", owner, (k + 1) % 4);
        end

        // ---------------- 3: ptr=2, ch2 absent -> ch3 ----------------
        req = 4'b0000;
        wait_idle(10);
        ticks(2);
        req = 4'b0010;
        wait_grant(10);
        check("t3_ch1_gnt", gnt, 4'b0010);
        req = 4'b0000;
        wait_idle(10);
        ticks(3);
        req = 4'b1011;
        ticks(2);
        check("t3_gnt_c2", gnt, 4'b0000);
        tick();
        check("t3_gnt",   gnt,   4'b1000);
        check("t3_owner", owner, 3);
        req = 4'b0000;
        wait_idle(10);
        ticks(3);

        // ---------------- 4: timeout revoke ----------------
        req = 4'b0001;
        ticks(3);
        check("t4_ch0_gnt", gnt, 4'b0001);
        req = 4'b0011;
        ticks(7);
        check("t4_hold_gnt",     gnt,     4'b0001);
        check("t4_hold_timeout", timeout, 0);
        tick();
        check("t4_rev_gnt",     gnt,     4'b0000);
        check("t4_rev_timeout", timeout, 1);
        check("t4_rev_busy",    busy,    0);
        tick();
        check("t4_guard_gnt",     gnt,     4'b0000);
        check("t4_guard_timeout", timeout, 0);
        tick();
        check("t4_ch1_gnt",   gnt,   4'b0010);
        check("t4_ch1_owner", owner, 1);
        req = 4'b0001;
        wait_idle(10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_stale_no_gnt", gnt, 4'b0000);
        end
        req = 4'b0000;
        ticks(3);
        req = 4'b0001;
        ticks(2);
        check("t4_regain_c2", gnt, 4'b0000);
        tick();
        check("t4_regain_gnt", gnt, 4'b0001);

        // ---------------- 5: no competitor, no revoke ----------------
        for (int i = 0; i < 100; i++) begin
            tick();
            check("t5_hold", {timeout, gnt}, 5'b00001);
        end
        req = 4'b0000;
        wait_idle(10);

        // ---------------- 6: random run, exclusion invariants ----------------
        for (int i = 0; i < 10000; i++) begin
            if (i % 3 == 0) req = N'($urandom);
            tick();
            check("r_onehot0",     {31'b0, $onehot0(gnt)},  32'd1);
            check("r_busy",        {31'b0, busy},           {31'b0, |gnt});
            check("r_timeout_gap", {31'b0, timeout & |gnt}, 32'd0);
        end

        // Asynchronous reset in the middle of a grant.
        req = N'($urandom) | 4'b0100;
        wait_grant(20);
        rst_n = 1'b0;
        #2;
        check("ar_gnt",     gnt,     0);
        check("ar_owner",   owner,   0);
        check("ar_busy",    busy,    0);
        check("ar_timeout", timeout, 0);
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        ticks(2);
        check("ar_restart_c2", gnt, 4'b0000);
        tick();
        check("ar_restart_gnt",   gnt,   4'b0001);
        check("ar_restart_owner", owner, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
